// File: rtl/adsb_crc_filter.sv
// ADS-B squitter filter: runs the 24-bit Mode S parity over the data bits and forwards only frames whose CRC (and optionally DF) match.
// Optional ADSB_CRC_STATS_EN adds saturating good/bad frame counters (good_count, bad_count).
module adsb_crc_filter #(
    parameter int SQUITTER_LENGTH = 112,
    parameter int DF_MATCH        = 17,
    parameter int DF_CHECK        = 1
) (
    input  logic                         s00_axis_aclk,
    input  logic                         s00_axis_aresetn,
    input  logic                         s00_axis_tvalid,
    input  logic [SQUITTER_LENGTH-1:0]   s00_axis_tdata,
    output logic                         s00_axis_tready,
    output logic                         m00_axis_tvalid,
    input  logic                         m00_axis_tready,
    output logic [SQUITTER_LENGTH-1:0]   m00_axis_tdata,
    output logic                         m00_axis_tlast,
    output logic [SQUITTER_LENGTH/8-1:0] m00_axis_tstrb
`ifdef ADSB_CRC_STATS_EN
    ,
    output logic [31:0]                  good_count,
    output logic [31:0]                  bad_count
`endif
);

    localparam int          DATA_BITS = SQUITTER_LENGTH - 24;
    localparam int          CNT_W     = $clog2(DATA_BITS);
    localparam int          IDX_W     = $clog2(SQUITTER_LENGTH);
    localparam logic [23:0] CRC_POLY  = 24'hFFF409;
    localparam logic [4:0]  DF_VAL    = 5'(DF_MATCH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CRC   = 2'd1,
        ST_CHECK = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    logic [1:0]                 r_rst_sync;
    logic                       w_rst_n;
    state_t                     r_state;
    state_t                     w_state_next;
    logic [SQUITTER_LENGTH-1:0] r_frame;
    logic [23:0]                r_rem;
    logic [CNT_W-1:0]           r_cnt;
    logic [IDX_W-1:0]           w_bit_idx;
    logic                       w_bit;
    logic                       w_fb;
    logic [23:0]                w_rem_next;
    logic                       w_accept;
    logic                       w_last_bit;
    logic                       w_df_ok;
    logic                       w_pass;

    // Reset asserts immediately but releases the FSM only after two clean clock edges.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_bit_idx  = IDX_W'(SQUITTER_LENGTH - 1) - IDX_W'(r_cnt);
    assign w_bit      = r_frame[w_bit_idx];
    assign w_fb       = r_rem[23] ^ w_bit;
    assign w_rem_next = {r_rem[22:0], 1'b0} ^ (w_fb ? CRC_POLY : 24'h000000);
    assign w_last_bit = (r_cnt == CNT_W'(DATA_BITS - 1));

    assign w_accept = (r_state == ST_IDLE) && s00_axis_tvalid;
    assign w_df_ok  = (DF_CHECK == 0) || (r_frame[SQUITTER_LENGTH-1 -: 5] == DF_VAL);
    assign w_pass   = (r_rem == r_frame[23:0]) && w_df_ok;

    always_ff @(posedge s00_axis_aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (s00_axis_tvalid) w_state_next = ST_CRC;
            ST_CRC:   if (w_last_bit) w_state_next = ST_CHECK;
            ST_CHECK: w_state_next = w_pass ? ST_OUT : ST_IDLE;
            ST_OUT:   if (m00_axis_tready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_frame <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_frame <= s00_axis_tdata;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_CRC) begin
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // tready is held low until the synchronised reset has released the FSM.
    assign s00_axis_tready = (r_state == ST_IDLE) && w_rst_n;
    assign m00_axis_tvalid = (r_state == ST_OUT);
    assign m00_axis_tdata  = r_frame;
    assign m00_axis_tlast  = 1'b1;
    assign m00_axis_tstrb  = '1;

`ifdef ADSB_CRC_STATS_EN
    logic [31:0] r_good_count;
    logic [31:0] r_bad_count;

    always_ff @(posedge s00_axis_aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_good_count <= '0;
            r_bad_count  <= '0;
        end else if (r_state == ST_CHECK) begin
            if (w_pass && (r_good_count != 32'hFFFF_FFFF)) begin
                r_good_count <= r_good_count + 32'd1;
            end
            if (!w_pass && (r_bad_count != 32'hFFFF_FFFF)) begin
                r_bad_count <= r_bad_count + 32'd1;
            end
        end
    end

    assign good_count = r_good_count;
    assign bad_count  = r_bad_count;
`endif

endmodule

// File: tb/tb_adsb_crc_filter.sv
// Directed bench for adsb_crc_filter: three instances (default, DF_MATCH=18 enforced, DF_MATCH=18 unchecked)
// share one input stream; a vector table plus hand sequences for backpressure, mid-frame reset and back-to-back.
module tb_adsb_crc_filter;

    localparam int SL = 112;

    logic          clk;
    logic          s_aresetn;
    logic          s_tvalid;
    logic [SL-1:0] s_tdata;
    logic          s_ready [3];
    logic          m_valid [3];
    logic          m_rdy   [3];
    logic [SL-1:0] m_data  [3];
    logic          m_last  [3];
    logic [SL/8-1:0] m_strb [3];
`ifdef ADSB_CRC_STATS_EN
    logic [31:0]   good_cnt [3];
    logic [31:0]   bad_cnt  [3];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    adsb_crc_filter #(.SQUITTER_LENGTH(SL), .DF_MATCH(17), .DF_CHECK(1)) u_dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(s_aresetn),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata), .s00_axis_tready(s_ready[0]),
        .m00_axis_tvalid(m_valid[0]), .m00_axis_tready(m_rdy[0]), .m00_axis_tdata(m_data[0]),
        .m00_axis_tlast(m_last[0]), .m00_axis_tstrb(m_strb[0])
`ifdef ADSB_CRC_STATS_EN
        , .good_count(good_cnt[0]), .bad_count(bad_cnt[0])
`endif
    );

    adsb_crc_filter #(.SQUITTER_LENGTH(SL), .DF_MATCH(18), .DF_CHECK(1)) u_dut_df18 (
        .s00_axis_aclk(clk), .s00_axis_aresetn(s_aresetn),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata), .s00_axis_tready(s_ready[1]),
        .m00_axis_tvalid(m_valid[1]), .m00_axis_tready(m_rdy[1]), .m00_axis_tdata(m_data[1]),
        .m00_axis_tlast(m_last[1]), .m00_axis_tstrb(m_strb[1])
`ifdef ADSB_CRC_STATS_EN
        , .good_count(good_cnt[1]), .bad_count(bad_cnt[1])
`endif
    );

    adsb_crc_filter #(.SQUITTER_LENGTH(SL), .DF_MATCH(18), .DF_CHECK(0)) u_dut_nodf (
        .s00_axis_aclk(clk), .s00_axis_aresetn(s_aresetn),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata), .s00_axis_tready(s_ready[2]),
        .m00_axis_tvalid(m_valid[2]), .m00_axis_tready(m_rdy[2]), .m00_axis_tdata(m_data[2]),
        .m00_axis_tlast(m_last[2]), .m00_axis_tstrb(m_strb[2])
`ifdef ADSB_CRC_STATS_EN
        , .good_count(good_cnt[2]), .bad_count(bad_cnt[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    localparam logic [SL-1:0] FRAME_A = 112'h8D4840D6202CC371C32CE0576098;
    localparam logic [SL-1:0] FRAME_B = 112'h8D406B902015A678D4D220AA4BDA;
    localparam logic [SL-1:0] ONE     = 112'd1;

    typedef struct {
        string         name;
        logic [SL-1:0] frame;
        logic [2:0]    exp_pass;   // bit d: instance d should forward the frame
    } vec_t;

    vec_t vecs[6];

    int            first_v    [3];
    int            nv         [3];
    int            first_idle [3];
    logic [SL-1:0] out_data   [3];

    task automatic chk(input string name, input logic [SL-1:0] act, input logic [SL-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one frame once every instance is idle, then observe ncyc cycles after acceptance.
    task automatic send(input logic [SL-1:0] f, input int ncyc);
        int guard = 0;
        while (!(s_ready[0] && s_ready[1] && s_ready[2]) && guard < 400) begin
            step();
            guard++;
        end
        chk("ready_wait_in_bound", SL'(guard < 400), ONE);
        s_tvalid = 1'b1;
        s_tdata  = f;
        step();
        s_tvalid = 1'b0;
        for (int d = 0; d < 3; d++) begin
            first_v[d] = 0; nv[d] = 0; first_idle[d] = 0; out_data[d] = '0;
        end
        for (int k = 1; k <= ncyc; k++) begin
            for (int d = 0; d < 3; d++) begin
                if (m_valid[d]) begin
                    nv[d]++;
                    if (first_v[d] == 0) begin
                        first_v[d]  = k;
                        out_data[d] = m_data[d];
                    end
                end
                if (s_ready[d] && first_idle[d] == 0) first_idle[d] = k;
            end
            step();
        end
    endtask

    initial begin
        int early, hi, bad_data, bad_rdy, acc_k, n_out, extra;
        int            out_k [2];
        logic [SL-1:0] out_d [2];

        // Expected pass per instance: [0]=DF17 checked, [1]=DF18 checked, [2]=DF unchecked.
        vecs[0] = '{"valid_a",       FRAME_A,                 3'b101};
        vecs[1] = '{"a_bit60_flip",  FRAME_A ^ (ONE << 60),   3'b000};
        vecs[2] = '{"all_zero_df0",  '0,                      3'b100};
        vecs[3] = '{"valid_b",       FRAME_B,                 3'b101};
        vecs[4] = '{"a_bit0_flip",   FRAME_A ^ ONE,           3'b000};
        vecs[5] = '{"a_bit111_flip", FRAME_A ^ (ONE << 111),  3'b000};

        s_aresetn = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        for (int d = 0; d < 3; d++) m_rdy[d] = 1'b1;

        step(); step(); step();
        chk("rst_tready_low", SL'(s_ready[0]), '0);
        chk("rst_tvalid_low", SL'(m_valid[0]), '0);
        chk("rst_tdata_zero", m_data[0], '0);
        chk("tlast_const", SL'(m_last[0]), ONE);
        chk("tstrb_const", SL'(m_strb[0]), SL'(14'h3FFF));

        s_aresetn = 1'b1;
        step();
        chk("rst_sync_first_edge_tready", SL'(s_ready[0]), '0);
        step();
        chk("rst_sync_second_edge_tready", SL'(s_ready[0]), ONE);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].frame, 100);
            for (int d = 0; d < 3; d++) begin
                if (vecs[i].exp_pass[d]) begin
                    chk($sformatf("%s_i%0d_latency", vecs[i].name, d), SL'(first_v[d]), SL'(90));
                    chk($sformatf("%s_i%0d_beats", vecs[i].name, d), SL'(nv[d]), ONE);
                    chk($sformatf("%s_i%0d_data", vecs[i].name, d), out_data[d], vecs[i].frame);
                end else begin
                    chk($sformatf("%s_i%0d_no_output", vecs[i].name, d), SL'(nv[d]), '0);
                    chk($sformatf("%s_i%0d_idle_cycle", vecs[i].name, d), SL'(first_idle[d]), SL'(90));
                end
            end
        end

`ifdef ADSB_CRC_STATS_EN
        chk("stats_good_count", SL'(good_cnt[0]), SL'(2));
        chk("stats_bad_count", SL'(bad_cnt[0]), SL'(4));
        chk("stats_nodf_good_count", SL'(good_cnt[2]), SL'(3));
`endif

        // Backpressure: downstream stalls for the first 10 cycles of tvalid.
        m_rdy[0] = 1'b0;
        send(FRAME_A, 0);
        early = 0; hi = 0; bad_data = 0; bad_rdy = 0;
        for (int k = 1; k <= 89; k++) begin
            if (m_valid[0]) early++;
            step();
        end
        for (int j = 0; j <= 10; j++) begin
            if (m_valid[0]) hi++;
            if (m_data[0] !== FRAME_A) bad_data++;
            if (s_ready[0]) bad_rdy++;
            if (j == 10) m_rdy[0] = 1'b1;
            step();
        end
        chk("bp_no_early_valid", SL'(early), '0);
        chk("bp_valid_high_cycles", SL'(hi), SL'(11));
        chk("bp_data_unstable_cycles", SL'(bad_data), '0);
        chk("bp_tready_high_cycles", SL'(bad_rdy), '0);
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            if (m_valid[0]) extra++;
            step();
        end
        chk("bp_single_transfer", SL'(extra), '0);
        chk("bp_back_to_idle", SL'(s_ready[0]), ONE);

        // Reset in the middle of CRC discards the frame; the next frame goes through normally.
        send(FRAME_A, 0);
        early = 0;
        for (int k = 1; k < 40; k++) begin
            if (m_valid[0]) early++;
            step();
        end
        s_aresetn = 1'b0;
        #1;
        chk("midrst_tvalid_low", SL'(m_valid[0]), '0);
        chk("midrst_tready_low", SL'(s_ready[0]), '0);
        chk("midrst_tdata_zero", m_data[0], '0);
        for (int k = 0; k < 3; k++) begin
            if (m_valid[0]) early++;
            step();
        end
        s_aresetn = 1'b1;
        send(FRAME_B, 100);
        chk("midrst_no_output_first", SL'(early), '0);
        chk("midrst_second_latency", SL'(first_v[0]), SL'(90));
        chk("midrst_second_beats", SL'(nv[0]), ONE);
        chk("midrst_second_data", out_data[0], FRAME_B);

        // Back-to-back: input held valid, second frame presented right after the first is taken.
        // Next acceptance lands in the IDLE cycle after the 90-cycle CRC/CHECK/OUT pass.
        begin
            int guard = 0;
            while (!s_ready[0] && guard < 400) begin
                step();
                guard++;
            end
            chk("b2b_ready_wait_in_bound", SL'(guard < 400), ONE);
        end
        s_tvalid = 1'b1;
        s_tdata  = FRAME_A;
        step();
        s_tdata = FRAME_B;
        acc_k = 0; n_out = 0;
        out_k[0] = 0; out_k[1] = 0; out_d[0] = '0; out_d[1] = '0;
        for (int k = 1; k <= 200; k++) begin
            if (m_valid[0]) begin
                if (n_out < 2) begin
                    out_k[n_out] = k;
                    out_d[n_out] = m_data[0];
                end
                n_out++;
            end
            if (s_tvalid && s_ready[0] && acc_k == 0) acc_k = k;
            step();
            if (acc_k == k) s_tvalid = 1'b0;
        end
        s_tvalid = 1'b0;
        chk("b2b_accept_spacing", SL'(acc_k), SL'(91));
        chk("b2b_output_count", SL'(n_out), SL'(2));
        chk("b2b_first_cycle", SL'(out_k[0]), SL'(90));
        chk("b2b_first_data", out_d[0], FRAME_A);
        chk("b2b_second_cycle", SL'(out_k[1]), SL'(181));
        chk("b2b_second_data", out_d[1], FRAME_B);

        // Idle with tvalid low: output register keeps the last captured frame.
        s_tdata = '0;
        for (int k = 0; k < 5; k++) step();
        chk("idle_tdata_held", m_data[0], FRAME_B);
        chk("idle_tready_high", SL'(s_ready[0]), ONE);
        chk("idle_tvalid_low", SL'(m_valid[0]), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
